// File: rtl/fp_pkg.sv
// Shared types for the F-PM microstep sequencer: state encoding, opcode
// constants and opcode classification helpers.
package fp_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_F2,
    S_F4,
    S_F5,
    S_F6,
    S_F7,
    S_F8,
    S_F9,
    S_F10,
    S_F13,
    S_DONE
  } fp_state_e;

  // Arithmetic opcodes as carried on ir[7:9] (ir[7] is the MSB).
  localparam logic [2:0] AD = 3'b000;
  localparam logic [2:0] SD = 3'b001;
  localparam logic [2:0] MW = 3'b010;
  localparam logic [2:0] DW = 3'b011;
  localparam logic [2:0] AF = 3'b100;
  localparam logic [2:0] SF = 3'b101;
  localparam logic [2:0] MF = 3'b110;
  localparam logic [2:0] DF = 3'b111;

  // Floating-point ops occupy the upper half of the opcode space.
  function automatic logic is_float(input logic [2:0] op);
    return op[2];
  endfunction

  // Add/subtract (fixed or float) have the middle opcode bit clear.
  function automatic logic is_addsub(input logic [2:0] op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/fp_seq_if.sv
// Bundle between CPU control / F-PM and the microstep sequencer.
//
// Handshake: fstart is a one-cycle request, accepted only while busy=0 and
// (pufa|nrf)=1; a request seen while busy=1 is dropped, never queued. Once
// accepted, busy stays high until the cycle that carries the one-cycle fend
// pulse (inclusive). ir/pufa/nrf only need to be valid up to and including
// the CLR cycle (the cycle with _0_f=1); fic/nz/wt/ws are sampled in the
// strob2_fp cycle of the state that consumes them.
interface fp_seq_if;
  import fp_pkg::*;

  logic       fstart;
  logic       pufa;
  logic       nrf;
  logic [7:9] ir;
  logic       fic;
  logic       nz;
  logic       wt;
  logic       ws;

  logic       _0_f;
  logic       f2_;
  logic       f4_;
  logic       f5_;
  logic       f6_;
  logic       f7_;
  logic       f8_;
  logic       f10_;
  logic       f9;
  logic       f13;
  logic       strob_fp;
  logic       strob2_fp;
  logic       busy;
  logic       fend;
  logic       ferr;
  fp_state_e  state;

  modport master (
    output fstart, pufa, nrf, ir, fic, nz, wt, ws,
    input  _0_f, f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13,
    input  strob_fp, strob2_fp, busy, fend, ferr, state
  );

  modport slave (
    input  fstart, pufa, nrf, ir, fic, nz, wt, ws,
    output _0_f, f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13,
    output strob_fp, strob2_fp, busy, fend, ferr, state
  );

endinterface

// File: rtl/fp_phase.sv
// A/B strobe phase generator. restart starts a fresh A phase on the next
// cycle; while run is high the strobes alternate A,B,A,B...; otherwise both
// strobes are idle. Both strobes are registered and never overlap.
module fp_phase (
  input  logic clk,
  input  logic clr,
  input  logic run,
  input  logic restart,
  output logic strob_fp,
  output logic strob2_fp,
  output logic phase_b
);

  // Phase register: A -> B -> A while running, forced to A on restart.
  always_ff @(posedge clk) begin
    if (clr) begin
      strob_fp  <= 1'b0;
      strob2_fp <= 1'b0;
    end else if (restart) begin
      strob_fp  <= 1'b1;
      strob2_fp <= 1'b0;
    end else if (run) begin
      strob_fp  <= strob2_fp;
      strob2_fp <= ~strob2_fp;
    end else begin
      strob_fp  <= 1'b0;
      strob2_fp <= 1'b0;
    end
  end

  // Phase B is exactly the cycle carrying the second strobe.
  assign phase_b = strob2_fp;

endmodule

// File: rtl/fp_seq.sv
// F-PM microstep sequencer. Walks the F2..F13 microstates for the latched
// opcode, one A/B strobe pair per state visit, and reports completion with
// a one-cycle fend pulse. All outputs are registered.
module fp_seq
  import fp_pkg::*;
#(
  parameter int LOOP_MAX = 63
) (
  input logic       __clk,
  input logic       clr,
  fp_seq_if.slave   bus
);

  fp_state_e  state;
  fp_state_e  nxt;
  logic [3:0] op;          // {nrf, ir} captured in CLR
  logic       end_flag;    // set once F10 has been visited
  logic [5:0] loop_cnt;
  logic [6:0] cnt_inc;
  logic       cap_hit;
  logic       cap_exit;
  logic       in_f;
  logic       strob_a;
  logic       strob_b;
  logic       phase_b;
  logic       run;
  logic       restart;

  wire        op_nrf  = op[3];
  wire [2:0]  op_code = op[2:0];

  assign in_f    = state inside {S_F2, S_F4, S_F5, S_F6, S_F7, S_F8, S_F9, S_F10, S_F13};
  // The phase pair stops after F13 phase B so DONE carries no strobe.
  assign run     = in_f & ~((state == S_F13) & phase_b);
  assign restart = (state == S_CLR);

  fp_phase u_phase (
    .clk       (__clk),
    .clr       (clr),
    .run       (run),
    .restart   (restart),
    .strob_fp  (strob_a),
    .strob2_fp (strob_b),
    .phase_b   (phase_b)
  );

  assign bus.strob_fp  = strob_a;
  assign bus.strob2_fp = strob_b;
  assign bus.state     = state;

  // Next-state decision; F states only move on in phase B.
  always_comb begin
    cnt_inc  = {1'b0, loop_cnt} + 7'd1;
    cap_hit  = (cnt_inc == 7'(LOOP_MAX));
    cap_exit = 1'b0;
    nxt      = state;
    case (state)
      S_IDLE: if (bus.fstart && (bus.pufa || bus.nrf)) nxt = S_CLR;
      S_CLR:  nxt = S_F2;
      S_F2:   if (phase_b) nxt = op_nrf ? S_F6 : S_F4;
      S_F4: begin
        if (phase_b) begin
          if (is_addsub(op_code) && is_float(op_code)) nxt = S_F5;
          else if (is_addsub(op_code))                 nxt = S_F7;
          else                                         nxt = S_F8;
        end
      end
      S_F5:   if (phase_b) nxt = bus.wt ? S_F13 : S_F8;
      S_F8: begin
        if (phase_b && (bus.fic || cap_hit)) begin
          cap_exit = cap_hit;
          if (op_code == DW || op_code == DF) nxt = S_F9;
          else if (op_code == MW)             nxt = S_F13;
          else                                nxt = S_F6;
        end
      end
      S_F9:   if (phase_b) nxt = (op_code == DW) ? S_F13 : S_F6;
      S_F6: begin
        if (phase_b && (!bus.nz || cap_hit)) begin
          cap_exit = cap_hit;
          nxt      = S_F7;
        end
      end
      S_F7: begin
        if (phase_b) begin
          if (!op_nrf && is_float(op_code) && bus.ws && !end_flag) nxt = S_F10;
          else                                                     nxt = S_F13;
        end
      end
      S_F10:  if (phase_b) nxt = S_F6;
      S_F13:  if (phase_b) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Sequencer state, registered state lines and status flags.
  always_ff @(posedge __clk) begin
    if (clr) begin
      state    <= S_IDLE;
      op       <= 4'd0;
      end_flag <= 1'b0;
      loop_cnt <= 6'd0;
      bus._0_f <= 1'b0;
      bus.busy <= 1'b0;
      bus.fend <= 1'b0;
      bus.ferr <= 1'b0;
      bus.f2_  <= 1'b1;
      bus.f4_  <= 1'b1;
      bus.f5_  <= 1'b1;
      bus.f6_  <= 1'b1;
      bus.f7_  <= 1'b1;
      bus.f8_  <= 1'b1;
      bus.f10_ <= 1'b1;
      bus.f9   <= 1'b0;
      bus.f13  <= 1'b0;
    end else begin
      state    <= nxt;
      bus._0_f <= (nxt == S_CLR);
      bus.busy <= (nxt != S_IDLE);
      bus.fend <= (nxt == S_DONE);
      bus.f2_  <= (nxt != S_F2);
      bus.f4_  <= (nxt != S_F4);
      bus.f5_  <= (nxt != S_F5);
      bus.f6_  <= (nxt != S_F6);
      bus.f7_  <= (nxt != S_F7);
      bus.f8_  <= (nxt != S_F8);
      bus.f10_ <= (nxt != S_F10);
      bus.f9   <= (nxt == S_F9);
      bus.f13  <= (nxt == S_F13);

      if (state == S_CLR) op <= {bus.nrf, bus.ir};

      if (nxt == S_CLR) begin
        bus.ferr <= 1'b0;
        end_flag <= 1'b0;
      end else begin
        if (cap_exit) bus.ferr <= 1'b1;
        if (state == S_F10) end_flag <= 1'b1;
      end

      // Counter restarts on loop entry and counts completed iterations.
      if ((nxt == S_F6 || nxt == S_F8) && nxt != state)
        loop_cnt <= 6'd0;
      else if (phase_b && (state == S_F6 || state == S_F8) && nxt == state)
        loop_cnt <= cnt_inc[5:0];
    end
  end

endmodule

// File: tb/tb_fp_seq.sv
// Bench for fp_seq: per-cycle expected output vectors are built from the
// intended state visit list of each scenario and compared cycle by cycle.
module tb_fp_seq;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  fp_seq_if bus ();

  fp_seq #(.LOOP_MAX(63)) dut (
    .__clk (clk),
    .clr   (clr),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [14:0] exp_q[$];
  fp_state_e   cur_q[$];
  fp_state_e   nxt_q[$];
  fp_state_e   visits[$];
  logic        exp_ferr;

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {busy, fend, _0_f, strob_fp, strob2_fp, ferr, f2_,f4_,f5_,f6_,f7_,f8_,f10_, f9, f13}
  function automatic logic [14:0] mk_vec(input logic busy, input logic fend, input logic f0,
                                         input logic sa, input logic sb, input logic ferr,
                                         input fp_state_e st);
    return {busy, fend, f0, sa, sb, ferr,
            st != S_F2, st != S_F4, st != S_F5, st != S_F6, st != S_F7, st != S_F8,
            st != S_F10, st == S_F9, st == S_F13};
  endfunction

  function automatic logic [14:0] obs();
    return {bus.busy, bus.fend, bus._0_f, bus.strob_fp, bus.strob2_fp, bus.ferr,
            bus.f2_, bus.f4_, bus.f5_, bus.f6_, bus.f7_, bus.f8_, bus.f10_, bus.f9, bus.f13};
  endfunction

  // Expected trace: CLR, one A/B pair per visit, DONE.
  task automatic build_trace(input int cap_idx);
    logic ferr;
    fp_state_e nx;
    exp_q.delete();
    cur_q.delete();
    nxt_q.delete();
    ferr = 1'b0;
    exp_q.push_back(mk_vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_IDLE));
    cur_q.push_back(S_CLR);
    nxt_q.push_back(S_F2);
    for (int i = 0; i < visits.size(); i++) begin
      nx = (i + 1 < visits.size()) ? visits[i+1] : S_DONE;
      exp_q.push_back(mk_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ferr, visits[i]));
      cur_q.push_back(visits[i]);
      nxt_q.push_back(nx);
      exp_q.push_back(mk_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ferr, visits[i]));
      cur_q.push_back(visits[i]);
      nxt_q.push_back(nx);
      if (i == cap_idx) ferr = 1'b1;
    end
    exp_q.push_back(mk_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ferr, S_IDLE));
    cur_q.push_back(S_DONE);
    nxt_q.push_back(S_IDLE);
    exp_ferr = ferr;
  endtask

  // Start one sequence (called 1 time unit after a rising edge) and follow it.
  task automatic run_seq(input string tag, input logic nrf, input logic [2:0] ir,
                         input logic ws_hold, input logic nz_hold,
                         input int cap_idx, input int clr_at);
    int c;
    fp_state_e cur;
    fp_state_e nx;
    build_trace(cap_idx);
    if (clr_at > 0) begin
      while (exp_q.size() > clr_at) begin
        void'(exp_q.pop_back());
        void'(cur_q.pop_back());
        void'(nxt_q.pop_back());
      end
      exp_q.push_back(mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE));
      cur_q.push_back(S_IDLE);
      nxt_q.push_back(S_IDLE);
      exp_ferr = 1'b0;
    end
    bus.fstart = 1'b1;
    bus.pufa   = ~nrf;
    bus.nrf    = nrf;
    bus.ir     = ir;
    bus.fic    = 1'b0;
    bus.nz     = 1'b0;
    bus.wt     = 1'b0;
    bus.ws     = 1'b0;
    c = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      c++;
      bus.fstart = 1'b0;
      clr        = 1'b0;
      check(tag, obs(), exp_q.pop_front());
      cur = cur_q.pop_front();
      nx  = nxt_q.pop_front();
      if (c >= 2) begin
        bus.ir   = 3'($urandom_range(0, 7));
        bus.pufa = 1'($urandom_range(0, 1));
        bus.nrf  = 1'($urandom_range(0, 1));
      end
      if (c == 4) begin
        bus.fstart = 1'b1;
        bus.pufa   = 1'b1;
      end
      bus.fic = !(cur == S_F8 && nx == S_F8);
      bus.nz  = nz_hold || (cur == S_F6 && nx == S_F6);
      bus.wt  = (cur == S_F5 && nx == S_F13);
      bus.ws  = ws_hold || (cur == S_F7 && nx == S_F10);
      if (c == clr_at) clr = 1'b1;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      check({tag, "_idle"}, obs(), mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_ferr, S_IDLE));
    end
  endtask

  initial begin
    clr        = 1'b1;
    bus.fstart = 1'b0;
    bus.pufa   = 1'b0;
    bus.nrf    = 1'b0;
    bus.ir     = 3'b000;
    bus.fic    = 1'b0;
    bus.nz     = 1'b0;
    bus.wt     = 1'b0;
    bus.ws     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", obs(), mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE));
    clr = 1'b0;

    // fstart without a pending instruction must be ignored
    bus.fstart = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      bus.fstart = 1'b0;
      check("nostart", obs(), mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE));
    end

    visits = '{S_F2, S_F4, S_F7, S_F13};
    run_seq("ad", 1'b0, AD, 1'b0, 1'b0, -1, 0);

    visits = '{S_F2, S_F4, S_F8, S_F8, S_F8, S_F13};
    run_seq("mw", 1'b0, MW, 1'b0, 1'b0, -1, 0);

    visits = '{S_F2, S_F4, S_F5, S_F13};
    run_seq("af_wt", 1'b0, AF, 1'b0, 1'b0, -1, 0);

    visits = '{S_F2, S_F4, S_F5, S_F8, S_F6, S_F7, S_F13};
    run_seq("sf", 1'b0, SF, 1'b0, 1'b0, -1, 0);

    visits = '{S_F2, S_F4, S_F8, S_F6, S_F6, S_F7, S_F10, S_F6, S_F7, S_F13};
    run_seq("mf_ws", 1'b0, MF, 1'b1, 1'b0, -1, 0);

    visits = '{S_F2, S_F4, S_F8, S_F9, S_F13};
    run_seq("dw", 1'b0, DW, 1'b0, 1'b0, -1, 0);

    visits = '{S_F2, S_F4, S_F8, S_F9, S_F6, S_F7, S_F13};
    run_seq("df", 1'b0, DF, 1'b0, 1'b0, -1, 0);

    visits = '{S_F2, S_F6, S_F7, S_F13};
    run_seq("nrf", 1'b1, DF, 1'b1, 1'b0, -1, 0);

    // nz stuck high: F6 must give up after 63 iterations and flag ferr
    visits.delete();
    visits.push_back(S_F2);
    for (int i = 0; i < 63; i++) visits.push_back(S_F6);
    visits.push_back(S_F7);
    visits.push_back(S_F13);
    run_seq("nrf_cap", 1'b1, SD, 1'b0, 1'b1, 63, 0);

    // ferr is cleared by the next start
    visits = '{S_F2, S_F4, S_F7, S_F13};
    run_seq("sd", 1'b0, SD, 1'b0, 1'b0, -1, 0);

    // clr in F8 phase A (cycle 6) aborts without fend
    visits = '{S_F2, S_F4, S_F8, S_F8, S_F8, S_F13};
    run_seq("clr_abort", 1'b0, MW, 1'b0, 1'b0, -1, 6);

    visits = '{S_F2, S_F4, S_F7, S_F13};
    run_seq("ad_after_clr", 1'b0, AD, 1'b0, 1'b0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
